prog_counter: RTL and testbench

//   Parametrised programmable counter; next generation of the basic free-running
//   up-counter. Adds up/down direction, runtime limit, load, enable and three modes
//   (wrap, saturate, one-shot), plus terminal-count pulse and sticky overflow flag.

---
 rtl/prog_counter.sv | 101 ++++++++++
 tb/tb_prog_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
// Provides a terminal-count pulse, a sticky overflow flag, and IDLE/RUN/DONE control.
module prog_counter #(
  parameter int unsigned             WIDTH   = 32,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {M_WRAP, M_SAT, M_ONESHOT, M_RSVD} mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             ovf_d;
  logic             ovf_set;
  logic             terminal;
  mode_t            mode_e;

  assign mode_e   = mode_t'(mode);
  assign terminal = dir ? (count == '0) : (count >= limit);

  always_comb begin
    state_d = state_q;
    count_d = count;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    if (load) begin
      // load freezes the FSM and suppresses any step for this cycle
      count_d = load_val;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (en) begin
            if (terminal) begin
              tc_d = 1'b1;
              unique case (mode_e)
                M_SAT:     ovf_set = 1'b1;
                M_ONESHOT: state_d = DONE;
                default: begin
                  ovf_set = 1'b1;
                  count_d = dir ? limit : '0;
                end
              endcase
            end else begin
              count_d = dir ? (count - ONE) : (count + ONE);
            end
          end
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            count_d = dir ? limit : '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // a new terminal event outranks a simultaneous clear
    ovf_d = ovf_set | (ovf & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= RST_VAL;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      tc      <= tc_d;
      ovf     <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: per-cycle vector table with a scoreboard
// queue of expected outputs, plus a hand sequence for async reset mid-count.
module tb_prog_counter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, en, start, stop, load, dir, ovf_clr;
  logic [W-1:0] load_val, limit, count;
  logic [1:0]   mode;
  logic         tc, busy, done, ovf;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
    logic         done;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en, st, sp, dr;
    logic [W-1:0] lm;
    logic [1:0]   md;
    logic         oc;
    exp_t         e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = 0;

  prog_counter #(.WIDTH(W), .RST_VAL(8'd3)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .dir(dir), .limit(limit), .mode(mode), .ovf_clr(ovf_clr),
    .count(count), .tc(tc), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int ld, lv, en_i, st, sp, dr, lm, md, oc,
                              input int c, t, b, d, o);
    vec_t v;
    v.ld = ld[0]; v.lv = lv[W-1:0]; v.en = en_i[0]; v.st = st[0]; v.sp = sp[0];
    v.dr = dr[0]; v.lm = lm[W-1:0]; v.md = md[1:0]; v.oc = oc[0];
    v.e.cnt = c[W-1:0]; v.e.tc = t[0]; v.e.busy = b[0]; v.e.done = d[0]; v.e.ovf = o[0];
    return v;
  endfunction

  task automatic compare(input string name);
    exp_t e, a;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    a = '{cnt: count, tc: tc, busy: busy, done: done, ovf: ovf};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tc=%b busy=%b done=%b ovf=%b, expected cnt=%0d tc=%b busy=%b done=%b ovf=%b",
               name, a.cnt, a.tc, a.busy, a.done, a.ovf, e.cnt, e.tc, e.busy, e.done, e.ovf);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    load = v.ld; load_val = v.lv; en = v.en; start = v.st; stop = v.sp;
    dir = v.dr; limit = v.lm; mode = v.md; ovf_clr = v.oc;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    compare($sformatf("row%0d", row));
    row++;
  endtask

  initial begin
    //                  ld lv en st sp dr lm md oc   cnt tc b d o
    // wrap up, limit 3
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0, 0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0,    1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0,    2, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0,    3, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0,    0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0,    1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0,    1, 0, 1, 0, 1));
    // load beats step; load_val above limit makes next up step terminal
    tbl.push_back(mk(1,10, 1, 0, 0, 0, 7, 0, 0,   10, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 7, 0, 0,    0, 1, 1, 0, 1));
    // limit 0, ovf set/clear collision, clear alone, back-to-back tc
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,    0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,    0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,    0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0, 0));
    // saturate down from 2, then stop
    tbl.push_back(mk(1, 2, 0, 0, 0, 1, 5, 1, 0,    2, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5, 1, 0,    1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5, 1, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5, 1, 0,    0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5, 1, 0,    0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 5, 1, 0,    0, 0, 0, 0, 1));
    // wrap down reloads limit
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 5, 0, 0,    0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5, 0, 0,    5, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5, 0, 0,    4, 0, 1, 0, 1));
    // one-shot up, limit 4
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4, 2, 0,    0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 2, 1,    0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    2, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    3, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    4, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    4, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 4, 2, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 2, 0,    1, 0, 1, 0, 0));
    // stop beats start; stop ignored in IDLE
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 4, 2, 0,    1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 4, 2, 0,    1, 0, 0, 0, 0));
    // reserved mode acts as wrap
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3, 0,    1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 3, 0,    0, 1, 1, 0, 1));
    // one-shot finish then restart counting down presets limit
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 2, 2, 0,    2, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 2, 2, 0,    2, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 6, 2, 0,    6, 0, 1, 0, 1));
    // run up to 5 for the async reset sequence
    tbl.push_back(mk(1, 4, 0, 0, 0, 0,20, 0, 0,    4, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,20, 0, 0,    5, 0, 1, 0, 1));

    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; dir = 1'b0;
    ovf_clr = 1'b0; load_val = '0; limit = '0; mode = 2'b00;
    #2;
    sb.push_back('{cnt: 8'd3, tc: 1'b0, busy: 1'b0, done: 1'b0, ovf: 1'b0});
    compare("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // asynchronous reset between edges, mid-count at 5
    #2;
    rst = 1'b1;
    #1;
    sb.push_back('{cnt: 8'd3, tc: 1'b0, busy: 1'b0, done: 1'b0, ovf: 1'b0});
    compare("async_rst");
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 0, 1, 1, 0, 0, 20, 0, 0,  3, 0, 1, 0, 0));
    apply(mk(0, 0, 1, 0, 0, 0, 20, 0, 0,  4, 0, 1, 0, 0));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
